ni_tx_arbiter: RTL and testbench



---
 rtl/ni_pkg.sv | 23 ++
 rtl/rr_arb_pick.sv | 33 +++
 rtl/ni_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_ni_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_pkg.sv
// Shared NI definitions: default payload/destination widths, arbiter state
// encoding and a constant-friendly ceil(log2) helper.
package ni_pkg;

  localparam int NI_DATA_W = 32;
  localparam int NI_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OFFER = 2'b01,
    HOLD  = 2'b10,
    DRAIN = 2'b11
  } arb_state_t;

  // Index width for 'value' items; never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first eligible bit at or above ptr,
// wrapping modulo N. Shared by the transmit arbiter and future demuxes.
module rr_arb_pick
  import ni_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          eligible,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [clog2(N)-1:0]   winner,
  output logic                  any_valid
);

  localparam int PW = clog2(N);

  logic [PW:0] idx;

  // Scan from the farthest offset down so the nearest eligible bit wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = {1'b0, ptr} + (PW + 1)'(off);
      if (idx >= (PW + 1)'(N)) idx = idx - (PW + 1)'(N);
      if (eligible[idx[PW-1:0]]) begin
        winner    = idx[PW-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ni_tx_arbiter.sv
// Round-robin arbiter sharing one NI injection port among NUM_REQ requesters.
// One captured word is offered at a time; HOLD skips the NI's stale ready and
// DRAIN waits for the NI to finish sending before the next grant.
module ni_tx_arbiter
  import ni_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = NI_DATA_W,
  parameter int ADDR_W  = NI_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_dest,
  input  logic [NUM_REQ-1:0]          req_en,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [DATA_W-1:0]           ni_data_in,
  output logic [ADDR_W-1:0]           ni_dest_add,
  output logic                        ni_proc_valid,
  input  logic                        ni_proc_ready,
  output logic [clog2(NUM_REQ)-1:0]   grant_id,
  output logic                        busy,
  output logic                        err_timeout
);

  localparam int ID_W = clog2(NUM_REQ);
  localparam logic [15:0]     TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

  arb_state_t state_reg, state_next;
  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [15:0]        timer_reg, timer_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic [ADDR_W-1:0]  dest_reg, dest_next;
  logic               valid_reg, valid_next;
  logic [ID_W-1:0]    grant_reg, grant_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;

  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [ADDR_W-1:0]  dest_arr [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      assign dest_arr[gi] = req_dest[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  assign eligible = req_valid & req_en;

  rr_arb_pick #(.N(NUM_REQ)) u_pick (
    .eligible  (eligible),
    .ptr       (rr_ptr_reg),
    .winner    (pick_id),
    .any_valid (pick_any)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      timer_reg  <= '0;
      ack_reg    <= '0;
      data_reg   <= '0;
      dest_reg   <= '0;
      valid_reg  <= 1'b0;
      grant_reg  <= '0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      timer_reg  <= timer_next;
      ack_reg    <= ack_next;
      data_reg   <= data_next;
      dest_reg   <= dest_next;
      valid_reg  <= valid_next;
      grant_reg  <= grant_next;
      busy_reg   <= busy_next;
      err_reg    <= err_next;
    end
  end

  // Next-state and next-output decode; ack is a pulse so it defaults low.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    timer_next  = timer_reg;
    ack_next    = '0;
    data_next   = data_reg;
    dest_next   = dest_reg;
    valid_next  = valid_reg;
    grant_next  = grant_reg;
    busy_next   = busy_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          data_next         = data_arr[pick_id];
          dest_next         = dest_arr[pick_id];
          ack_next[pick_id] = 1'b1;
          grant_next        = pick_id;
          rr_ptr_next       = (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
          valid_next        = 1'b1;
          busy_next         = 1'b1;
          timer_next        = '0;
          state_next        = OFFER;
        end
      end
      OFFER: begin
        if (ni_proc_ready) begin
          valid_next = 1'b0;
          state_next = HOLD;
        end else begin
          if (timer_reg != 16'hFFFF) timer_next = timer_reg + 16'd1;
          if (timer_reg == TIMER_LAST) err_next = 1'b1;
        end
      end
      // Ready seen here is the NI's pre-accept value; ignore it.
      HOLD: state_next = DRAIN;
      DRAIN: begin
        if (ni_proc_ready) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ack       = ack_reg;
  assign ni_data_in    = data_reg;
  assign ni_dest_add   = dest_reg;
  assign ni_proc_valid = valid_reg;
  assign grant_id      = grant_reg;
  assign busy          = busy_reg;
  assign err_timeout   = err_reg;

endmodule

// File: tb/tb_ni_tx_arbiter.sv
// Directed bench for ni_tx_arbiter with a small NI ready model.
module tb_ni_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 20;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*ADDR_W-1:0] req_dest;
  logic [NUM_REQ-1:0]        req_en;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         ni_data_in;
  logic [ADDR_W-1:0]         ni_dest_add;
  logic                      ni_proc_valid;
  logic                      ni_proc_ready;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      err_timeout;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int send_len = 6;
  bit ni_auto = 1'b1;
  logic force_ready = 1'b0;

  logic model_ready;
  int   model_cnt;

  always #5 clk = ~clk;

  ni_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_dest(req_dest),
    .req_en(req_en), .req_ack(req_ack), .ni_data_in(ni_data_in), .ni_dest_add(ni_dest_add),
    .ni_proc_valid(ni_proc_valid), .ni_proc_ready(ni_proc_ready), .grant_id(grant_id),
    .busy(busy), .err_timeout(err_timeout)
  );

  // NI model: registered ready drops after an accept, returns send_len edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_ready <= 1'b1;
      model_cnt   <= 0;
    end else if (ni_proc_valid && ni_proc_ready) begin
      model_ready <= 1'b0;
      model_cnt   <= send_len;
    end else if (!model_ready) begin
      if (model_cnt <= 1) model_ready <= 1'b1;
      model_cnt <= model_cnt - 1;
    end
  end

  assign ni_proc_ready = ni_auto ? model_ready : force_ready;

  task automatic tick;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic set_words;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = 32'hC0DE_0000 | 32'(i);
      req_dest[i*ADDR_W +: ADDR_W] = 2'(i);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int id, output int at, output bit ok);
    ok = 1'b0;
    id = -1;
    at = -1;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick;
      if (req_ack != '0) begin
        ok = 1'b1;
        at = cycle;
        for (int b = 0; b < NUM_REQ; b++) if (req_ack[b]) id = b;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++; if (ni_proc_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ni_proc_valid); end
    checks++; if (ni_data_in !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", ni_data_in); end
    checks++; if (ni_dest_add !== 2'b00) begin failures++; $display("FAIL reset_dest got=%b exp=00", ni_dest_add); end
    checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", req_ack); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    rst = 1'b0;
    // Ready high with no request must leave the arbiter idle.
    for (int k = 0; k < 3; k++) tick;
    checks++; if (ni_proc_valid !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000) begin
      failures++; $display("FAIL idle_ready valid=%b busy=%b ack=%b exp=0/0/0000", ni_proc_valid, busy, req_ack);
    end
    $display("test_reset done at cycle %0d", cycle);
  endtask

  task automatic test_single;
    int n;
    do_reset;
    send_len = 6;
    req_en = 4'b1111;
    req_data[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
    req_dest[1*ADDR_W +: ADDR_W] = 2'b10;
    req_valid = 4'b0010;
    tick;
    checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", req_ack); end
    checks++; if (ni_proc_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", ni_proc_valid); end
    checks++; if (ni_data_in !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", ni_data_in); end
    checks++; if (ni_dest_add !== 2'b10) begin failures++; $display("FAIL single_dest got=%b exp=10", ni_dest_add); end
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL single_grant got=%0d exp=1", grant_id); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    // Clearing the enable after capture must not abort the transfer.
    req_valid = 4'b0000;
    req_en = 4'b0000;
    tick;
    checks++; if (ni_proc_valid !== 1'b0 || req_ack !== 4'b0000 || busy !== 1'b1) begin
      failures++; $display("FAIL single_accept valid=%b ack=%b busy=%b exp=0/0000/1", ni_proc_valid, req_ack, busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin tick; n++; end
    checks++; if (n !== 7) begin failures++; $display("FAIL single_busy_fall got=%0d exp=7 cycles", n); end
    req_en = 4'b1111;
    $display("single grant id=1 data=deadbeef busy_cycles_after_accept=%0d", n);
  endtask

  task automatic test_round_robin;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int id, at;
    bit ok;
    do_reset;
    send_len = 6;
    req_en = 4'b1111;
    set_words;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(id, at, ok);
      checks++; if (!ok || id !== exp_order[k]) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, id, exp_order[k]); end
      checks++; if (grant_id !== 2'(exp_order[k]) || ni_data_in !== (32'hC0DE_0000 | 32'(exp_order[k]))) begin
        failures++; $display("FAIL rr_payload[%0d] grant=%0d data=%h exp=%0d", k, grant_id, ni_data_in, exp_order[k]);
      end
      $display("rr grant k=%0d id=%0d cycle=%0d data=%h", k, id, at, ni_data_in);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_enable_mask;
    int exp_order[4] = '{1, 3, 1, 3};
    int id, at;
    bit ok;
    do_reset;
    send_len = 6;
    set_words;
    req_en = 4'b1010;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(id, at, ok);
      checks++; if (!ok || id !== exp_order[k] || grant_id !== 2'(exp_order[k])) begin
        failures++; $display("FAIL mask_order[%0d] got=%0d grant=%0d exp=%0d", k, id, grant_id, exp_order[k]);
      end
      $display("mask grant k=%0d id=%0d cycle=%0d", k, id, at);
    end
    req_valid = 4'b0000;
    req_en = 4'b1111;
  endtask

  task automatic test_back_to_back;
    int id, at, prev_at;
    bit ok;
    do_reset;
    send_len = 1;
    set_words;
    req_en = 4'b1111;
    req_valid = 4'b1111;
    wait_grant(id, prev_at, ok);
    checks++; if (!ok || id !== 0) begin failures++; $display("FAIL b2b_first got=%0d exp=0", id); end
    for (int k = 1; k < 5; k++) begin
      wait_grant(id, at, ok);
      checks++; if (!ok || at - prev_at !== 4 || id !== (k % 4)) begin
        failures++; $display("FAIL b2b_interval[%0d] id=%0d gap=%0d exp id=%0d gap=4", k, id, at - prev_at, k % 4);
      end
      $display("b2b grant k=%0d id=%0d gap=%0d", k, id, at - prev_at);
      prev_at = at;
    end
    req_valid = 4'b0000;
    send_len = 6;
  endtask

  task automatic test_timeout;
    do_reset;
    send_len = 6;
    ni_auto = 1'b0;
    force_ready = 1'b0;
    req_en = 4'b1111;
    req_data[0 +: DATA_W] = 32'h1234_5678;
    req_dest[0 +: ADDR_W] = 2'b11;
    req_valid = 4'b0001;
    tick;
    checks++; if (req_ack !== 4'b0001 || ni_proc_valid !== 1'b1) begin
      failures++; $display("FAIL to_capture ack=%b valid=%b exp=0001/1", req_ack, ni_proc_valid);
    end
    req_valid = 4'b0000;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick;
      checks++; if (err_timeout !== 1'b0 || ni_proc_valid !== 1'b1 || ni_data_in !== 32'h1234_5678) begin
        failures++; $display("FAIL to_early[%0d] err=%b valid=%b data=%h exp=0/1/12345678", k, err_timeout, ni_proc_valid, ni_data_in);
      end
    end
    tick;
    checks++; if (err_timeout !== 1'b1 || ni_proc_valid !== 1'b1) begin
      failures++; $display("FAIL to_rise err=%b valid=%b exp=1/1", err_timeout, ni_proc_valid);
    end
    force_ready = 1'b1;
    tick;
    checks++; if (ni_proc_valid !== 1'b0 || busy !== 1'b1 || err_timeout !== 1'b1) begin
      failures++; $display("FAIL to_late_accept valid=%b busy=%b err=%b exp=0/1/1", ni_proc_valid, busy, err_timeout);
    end
    tick;
    tick;
    checks++; if (busy !== 1'b0 || err_timeout !== 1'b1) begin
      failures++; $display("FAIL to_drain busy=%b err=%b exp=0/1", busy, err_timeout);
    end
    $display("timeout transfer completed at cycle %0d err=%b", cycle, err_timeout);
    ni_auto = 1'b1;
    for (int k = 0; k < 10; k++) tick;
  endtask

  task automatic test_reset_mid;
    set_words;
    send_len = 6;
    req_en = 4'b1111;
    req_valid = 4'b1111;
    tick;
    checks++; if (req_ack !== 4'b0010 || grant_id !== 2'd1) begin
      failures++; $display("FAIL mid_pre_grant ack=%b grant=%0d exp=0010/1", req_ack, grant_id);
    end
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ni_proc_valid !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0 || req_ack !== 4'b0000 ||
                  grant_id !== 2'd0 || ni_data_in !== 32'h0 || ni_dest_add !== 2'b00) begin
      failures++; $display("FAIL mid_async_reset valid=%b busy=%b err=%b ack=%b grant=%0d data=%h dest=%b exp all 0",
                           ni_proc_valid, busy, err_timeout, req_ack, grant_id, ni_data_in, ni_dest_add);
    end
    tick;
    rst = 1'b0;
    tick;
    checks++; if (req_ack !== 4'b0001 || grant_id !== 2'd0) begin
      failures++; $display("FAIL mid_first_grant ack=%b grant=%0d exp=0001/0", req_ack, grant_id);
    end
    $display("post-reset grant id=%0d cycle=%0d", grant_id, cycle);
    req_valid = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_en = '1;
    req_data = '0;
    req_dest = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_enable_mask;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
